// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares one single-port data memory between two word-access requesters:
//   port 0 is the CPU load/store unit, port 1 is the program/data loader.
//   Each access runs IDLE -> ISSUE -> (WAIT) -> DONE. The address is checked
//   for word alignment and range before anything reaches the memory.
//
// Handshake (both ports): the requester raises Mx_REQ with WE/ADDR/WDATA
//   stable and holds it until Mx_DONE. REQ is only looked at in IDLE, where
//   the request fields are latched for the whole access. Mx_DONE is a
//   one-cycle pulse and Mx_ERR is meaningful only while Mx_DONE is high.
//   Mx_RDATA keeps the last successfully read word for that port.
//
// Ports:
//   CLK, RESET                  clock, synchronous active-high reset
//   M0_*/M1_*                   requester ports (REQ, WE, ADDR, WDATA in;
//                               RDATA, DONE, ERR out)
//   MRd, MWrt, ADDR, W_DATA     registered memory controls (out)
//   R_DATA                      memory read data (in)
//   BUSY                        high whenever the FSM is not in IDLE
//   state_dbg                   current FSM state, for observation only
module data_mem_arbiter #(
  parameter int RD_LATENCY = 1,
  parameter int MEM_BYTES  = 1024,
  parameter int ARB_MODE   = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        M0_REQ,
  input  logic        M0_WE,
  input  logic [31:0] M0_ADDR,
  input  logic [31:0] M0_WDATA,
  output logic [31:0] M0_RDATA,
  output logic        M0_DONE,
  output logic        M0_ERR,
  input  logic        M1_REQ,
  input  logic        M1_WE,
  input  logic [31:0] M1_ADDR,
  input  logic [31:0] M1_WDATA,
  output logic [31:0] M1_RDATA,
  output logic        M1_DONE,
  output logic        M1_ERR,
  output logic        MRd,
  output logic        MWrt,
  output logic [31:0] ADDR,
  output logic [31:0] W_DATA,
  input  logic [31:0] R_DATA,
  output logic        BUSY,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0]  LAT_M1    = 4'(RD_LATENCY - 1);
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  state_t      state, state_next;
  logic        gnt_q;      // port being served
  logic        we_q;       // latched write flag
  logic        err_q;      // latched rejection flag
  logic        rr_ptr;     // round-robin: port favoured on the next tie
  logic [3:0]  cnt;        // remaining read cycles while in WAIT

  logic        any_req;
  logic        sel;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_err;
  logic        capture;

  // Arbitration and request validation. The error decision is taken on the
  // IDLE edge so that the registered MRd/MWrt are already 0 during the ISSUE
  // cycle of a rejected access; ISSUE then simply acts on err_q.
  always_comb begin
    any_req = M0_REQ | M1_REQ;
    if (M0_REQ && M1_REQ) begin
      sel = (ARB_MODE == 1) ? 1'b0 : rr_ptr;
    end else begin
      sel = M1_REQ;
    end
    sel_we    = sel ? M1_WE    : M0_WE;
    sel_addr  = sel ? M1_ADDR  : M0_ADDR;
    sel_wdata = sel ? M1_WDATA : M0_WDATA;
    sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr >= MEM_LIMIT);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (any_req) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (err_q || we_q || (RD_LATENCY <= 1)) state_next = S_DONE;
        else                                     state_next = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == 4'd1) state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // R_DATA is taken at the edge ending the last MRd cycle of a good read.
  always_comb begin
    capture = !err_q && !we_q &&
              (((state == S_ISSUE) && (RD_LATENCY <= 1)) ||
               ((state == S_WAIT) && (cnt == 4'd1)));
  end

  // Datapath: grant bookkeeping, memory controls, read counter, RDATA.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      rr_ptr   <= 1'b0;
      cnt      <= 4'd0;
      MRd      <= 1'b0;
      MWrt     <= 1'b0;
      ADDR     <= 32'd0;
      W_DATA   <= 32'd0;
      M0_RDATA <= 32'd0;
      M1_RDATA <= 32'd0;
    end else begin
      if ((state == S_IDLE) && any_req) begin
        gnt_q  <= sel;
        we_q   <= sel_we;
        err_q  <= sel_err;
        rr_ptr <= ~sel;
        MRd    <= !sel_err && !sel_we;
        MWrt   <= !sel_err && sel_we;
        ADDR   <= sel_err ? 32'd0 : sel_addr;
        W_DATA <= (!sel_err && sel_we) ? sel_wdata : 32'd0;
      end
      if (state == S_ISSUE) cnt <= LAT_M1;
      if (state == S_WAIT)  cnt <= cnt - 4'd1;
      // Memory controls are released on the edge that enters DONE.
      if (state_next == S_DONE) begin
        MRd    <= 1'b0;
        MWrt   <= 1'b0;
        ADDR   <= 32'd0;
        W_DATA <= 32'd0;
      end
      if (capture) begin
        if (gnt_q) M1_RDATA <= R_DATA;
        else       M0_RDATA <= R_DATA;
      end
    end
  end

  // Outputs decoded from the state.
  always_comb begin
    BUSY      = (state != S_IDLE);
    M0_DONE   = (state == S_DONE) && !gnt_q;
    M1_DONE   = (state == S_DONE) && gnt_q;
    M0_ERR    = M0_DONE && err_q;
    M1_ERR    = M1_DONE && err_q;
    state_dbg = state;
  end

endmodule
